store_drain_unit: RTL and testbench
===================================

STORE_DRAIN_UNIT -- requirements
Module: store_drain_unit

Interface
REQ-001 Parameter: RETRY_LIMIT, 15, consecutive rejected issues of one store before stall_err sets (1..15).
REQ-002 Parameter: CNT_W, 16, width of commit_count.
REQ-003 clock  input  1  single clock; all state updates on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sb_empty  input  1  retire store buffer holds no entry.
REQ-006 sb_dout  input  SQ_ENTRY_PACKET  head entry of retire store buffer, valid same cycle when sb_empty=0; only .addr (32) and .value (32) are used.
REQ-007 sb_rd_en  output  1  pop request to retire store buffer.
REQ-008 load_req  input  1  load path needs the memory bus this cycle; has priority.
REQ-009 proc2mem_command  output  2  BUS_NONE or BUS_STORE.
REQ-010 proc2mem_addr  output  32  store address.
REQ-011 proc2mem_data  output  64  store data.
REQ-012 proc2mem_size  output  2  always WORD.
REQ-013 mem2proc_response  input  4  nonzero = command accepted this cycle; 0 = rejected.
REQ-014 drain_req  input  1  level; request to empty all pending stores (halt/fence).
REQ-015 drained  output  1  no store held and sb_empty=1.
REQ-016 commit_count  output  CNT_W  number of stores accepted by memory.
REQ-017 stall_err  output  1  sticky: one store rejected RETRY_LIMIT consecutive times.

Function
REQ-018 One holding register (hold_vld, hold_addr, hold_value); states IDLE (hold_vld=0) and ISSUE (hold_vld=1).
REQ-019 sb_rd_en = !sb_empty && (!hold_vld || store accepted this cycle); it is combinational and not gated by load_req.
REQ-020 When sb_rd_en=1, sb_dout is captured into the holding register at the same posedge and hold_vld is 1 next cycle.
REQ-021 In ISSUE with load_req=0: proc2mem_command=BUS_STORE, proc2mem_addr={hold_addr[31:2],2'b00}, proc2mem_data={hold_value,hold_value}, proc2mem_size=WORD.
REQ-022 In ISSUE with load_req=1: proc2mem_command=BUS_NONE; the store is held; no retry is counted.
REQ-023 In IDLE: proc2mem_command=BUS_NONE; addr and data outputs are 0.
REQ-024 Acceptance = BUS_STORE driven && mem2proc_response!=0; on acceptance commit_count increments by 1 (wraps modulo 2^CNT_W), retry_cnt clears.
REQ-025 On acceptance with sb_empty=0, the next entry is loaded in the same cycle (back-to-back, 1 store/cycle peak); with sb_empty=1, go to IDLE.
REQ-026 Rejection (BUS_STORE driven, response 0): same store re-issued next eligible cycle; retry_cnt (4-bit) increments, saturating at RETRY_LIMIT.
REQ-027 When retry_cnt reaches RETRY_LIMIT, stall_err sets and stays 1 until reset; issuing continues.
REQ-028 Latency: entry at buffer head with hold empty, no load_req, memory accepting -> BUS_STORE on the cycle after sb_rd_en.
REQ-029 drained = !hold_vld && sb_empty, combinational; drain_req changes no behaviour except that while drain_req=1, load_req is ignored (stores take the bus).
REQ-030 Stores are issued strictly in buffer order; none dropped or duplicated.

Reset
REQ-031 On reset: hold_vld=0, retry_cnt=0, commit_count=0, stall_err=0; state IDLE.
REQ-032 During reset-asserted cycles: sb_rd_en=0, proc2mem_command=BUS_NONE; a reset mid-retry discards the held store.

Verification
REQ-033 Single store addr=0x0000_1004, value=0xDEAD_BEEF, response=1 -> sb_rd_en cycle 0, BUS_STORE cycle 1 with addr 0x0000_1004, data 0xDEADBEEF_DEADBEEF, commit_count=1, drained=1 cycle 2.
REQ-034 Four entries buffered, response always 3 -> four consecutive BUS_STORE cycles in order, sb_rd_en high cycles 0-3, commit_count=4.
REQ-035 Store held, load_req=1 for 3 cycles -> BUS_NONE for those 3 cycles, retry_cnt stays 0, store issued cycle after load_req drops.
REQ-036 Response=0 for 15 cycles then 2 -> stall_err=1 after 15th rejection, store then accepted, commit_count=1, stall_err remains 1.
REQ-037 drain_req=1 with load_req=1 and 2 stores pending -> both stores issued, drained=1 after second acceptance.
REQ-038 Reset asserted while store held and rejected -> next cycle BUS_NONE, commit_count=0, stall_err=0, hold_vld=0.

Source files
------------

// File: rtl/store_drain_unit_if.sv
// Shared store-entry and memory-bus types, plus the store buffer / memory bus
// bundle seen by the store drain unit (master) and its environment (slave).
package store_drain_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] value;
  } SQ_ENTRY_PACKET;

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  localparam logic [1:0] BYTE   = 2'h0;
  localparam logic [1:0] HALF   = 2'h1;
  localparam logic [1:0] WORD   = 2'h2;
  localparam logic [1:0] DOUBLE = 2'h3;
endpackage

interface store_drain_unit_if;
  logic                           sb_empty;
  store_drain_pkg::SQ_ENTRY_PACKET sb_dout;
  logic                           sb_rd_en;
  logic                           load_req;
  logic [1:0]                     proc2mem_command;
  logic [31:0]                    proc2mem_addr;
  logic [63:0]                    proc2mem_data;
  logic [1:0]                     proc2mem_size;
  logic [3:0]                     mem2proc_response;

  modport master (
    input  sb_empty, sb_dout, load_req, mem2proc_response,
    output sb_rd_en, proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
  );

  modport slave (
    output sb_empty, sb_dout, load_req, mem2proc_response,
    input  sb_rd_en, proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
  );
endinterface

// File: rtl/store_drain_unit.sv
// Drains retired stores to memory through a single holding register; loads
// win the bus unless a drain is requested, and rejected stores are retried.
module store_drain_unit
  import store_drain_pkg::*;
#(
  parameter int RETRY_LIMIT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  store_drain_unit_if.master   bus,
  input  logic                 drain_req,
  output logic                 drained,
  output logic [CNT_W-1:0]     commit_count,
  output logic                 stall_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam logic [3:0] LIMIT = 4'(RETRY_LIMIT);

  state_t           r_state;
  logic [31:0]      r_hold_addr;
  logic [31:0]      r_hold_value;
  logic [3:0]       r_retry_cnt;
  logic [CNT_W-1:0] r_commit_count;
  logic             r_stall_err;

  logic w_hold_vld;
  logic w_load_blk;
  logic w_issue;
  logic w_accept;
  logic w_reject;
  logic w_rd_en;

  assign w_hold_vld = (r_state == ISSUE);
  // A pending drain overrides load priority so stores always make progress.
  assign w_load_blk = bus.load_req && !drain_req;
  assign w_issue    = !reset && w_hold_vld && !w_load_blk;
  assign w_accept   = w_issue && (bus.mem2proc_response != 4'h0);
  assign w_reject   = w_issue && (bus.mem2proc_response == 4'h0);
  assign w_rd_en    = !reset && !bus.sb_empty && (!w_hold_vld || w_accept);

  assign bus.sb_rd_en         = w_rd_en;
  assign bus.proc2mem_command = w_issue ? BUS_STORE : BUS_NONE;
  assign bus.proc2mem_addr    = w_issue ? {r_hold_addr[31:2], 2'b00} : 32'h0;
  assign bus.proc2mem_data    = w_issue ? {r_hold_value, r_hold_value} : 64'h0;
  assign bus.proc2mem_size    = WORD;

  assign drained      = !w_hold_vld && bus.sb_empty;
  assign commit_count = r_commit_count;
  assign stall_err    = r_stall_err;

  always_ff @(posedge clock) begin
    if (w_rd_en) begin
      r_hold_addr  <= bus.sb_dout.addr;
      r_hold_value <= bus.sb_dout.value;
    end
    if (reset) begin
      r_state        <= IDLE;
      r_retry_cnt    <= 4'h0;
      r_commit_count <= '0;
      r_stall_err    <= 1'b0;
    end else begin
      // A refill in the accepting cycle keeps ISSUE for back-to-back stores.
      if (w_rd_en)
        r_state <= ISSUE;
      else if (w_accept)
        r_state <= IDLE;

      if (w_accept) begin
        r_commit_count <= r_commit_count + CNT_W'(1);
        r_retry_cnt    <= 4'h0;
      end else if (w_reject) begin
        if (r_retry_cnt < LIMIT)
          r_retry_cnt <= r_retry_cnt + 4'd1;
        if (r_retry_cnt >= LIMIT - 4'd1)
          r_stall_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_drain_unit.sv
// Directed bench for store_drain_unit: a queue-modelled store buffer feeds the
// DUT and a negedge monitor scores every accepted store against a scoreboard.
module tb_store_drain_unit;
  import store_drain_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        drain_req;
  logic        drained;
  logic [15:0] commit_count;
  logic        stall_err;

  store_drain_unit_if bus ();

  store_drain_unit #(.RETRY_LIMIT(15), .CNT_W(16)) dut (
    .clock        (clk),
    .reset        (rst),
    .bus          (bus),
    .drain_req    (drain_req),
    .drained      (drained),
    .commit_count (commit_count),
    .stall_err    (stall_err)
  );

  SQ_ENTRY_PACKET sbq[$];
  exp_t           expq[$];
  int             n_total = 0;
  int             n_pass  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic refresh();
    bus.sb_empty = (sbq.size() == 0);
    bus.sb_dout  = (sbq.size() != 0) ? sbq[0] : '0;
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] v, input bit expect_commit);
    SQ_ENTRY_PACKET e;
    exp_t x;
    e.addr  = a;
    e.value = v;
    sbq.push_back(e);
    if (expect_commit) begin
      x.addr = {a[31:2], 2'b00};
      x.data = {v, v};
      expq.push_back(x);
    end
    refresh();
  endtask

  // Advance one clock; returns at posedge+1 with the buffer popped if requested.
  task automatic tick();
    bit pop;
    @(negedge clk);
    pop = bus.sb_rd_en;
    @(posedge clk);
    #1;
    if (pop && sbq.size() != 0) void'(sbq.pop_front());
    refresh();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.proc2mem_command == BUS_STORE && bus.mem2proc_response != 4'h0) begin
      if (expq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_store: got addr %h data %h expected no store",
                 bus.proc2mem_addr, bus.proc2mem_data);
      end else begin
        e = expq.pop_front();
        check("store_addr", 64'(bus.proc2mem_addr), 64'(e.addr));
        check("store_data", bus.proc2mem_data, e.data);
        check("store_size", 64'(bus.proc2mem_size), 64'(WORD));
      end
    end
  end

  initial begin
    rst = 1'b1;
    drain_req = 1'b0;
    bus.load_req = 1'b0;
    bus.mem2proc_response = 4'h0;
    refresh();
    tick();
    tick();
    #1;
    check("rst_rd_en", 64'(bus.sb_rd_en), 64'd0);
    check("rst_cmd", 64'(bus.proc2mem_command), 64'(BUS_NONE));
    rst = 1'b0;
    #1;
    check("rst_commit", 64'(commit_count), 64'd0);
    check("rst_stall", 64'(stall_err), 64'd0);
    check("rst_drained", 64'(drained), 64'd1);
    check("idle_addr", 64'(bus.proc2mem_addr), 64'd0);
    check("idle_data", bus.proc2mem_data, 64'd0);

    // Single store
    bus.mem2proc_response = 4'h1;
    push_store(32'h0000_1004, 32'hDEAD_BEEF, 1'b1);
    #1;
    check("t1_rd_en_c0", 64'(bus.sb_rd_en), 64'd1);
    check("t1_cmd_c0", 64'(bus.proc2mem_command), 64'(BUS_NONE));
    tick();
    #1;
    check("t1_cmd_c1", 64'(bus.proc2mem_command), 64'(BUS_STORE));
    check("t1_rd_en_c1", 64'(bus.sb_rd_en), 64'd0);
    tick();
    #1;
    check("t1_commit", 64'(commit_count), 64'd1);
    check("t1_drained", 64'(drained), 64'd1);
    check("t1_cmd_c2", 64'(bus.proc2mem_command), 64'(BUS_NONE));

    // Four back-to-back stores, response 3
    bus.mem2proc_response = 4'h3;
    push_store(32'h0000_2000, 32'h1111_1111, 1'b1);
    push_store(32'h0000_2004, 32'h2222_2222, 1'b1);
    push_store(32'h0000_200B, 32'h3333_3333, 1'b1);
    push_store(32'h0000_200C, 32'h4444_4444, 1'b1);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_rd_en_c%0d", i), 64'(bus.sb_rd_en), 64'd1);
      if (i > 0) check($sformatf("t2_cmd_c%0d", i), 64'(bus.proc2mem_command), 64'(BUS_STORE));
      tick();
      #1;
    end
    check("t2_rd_en_c4", 64'(bus.sb_rd_en), 64'd0);
    check("t2_cmd_c4", 64'(bus.proc2mem_command), 64'(BUS_STORE));
    tick();
    #1;
    check("t2_commit", 64'(commit_count), 64'd5);
    check("t2_drained", 64'(drained), 64'd1);

    // Load priority for three cycles
    bus.mem2proc_response = 4'h1;
    bus.load_req = 1'b1;
    push_store(32'h0000_5010, 32'h0BAD_F00D, 1'b1);
    #1;
    check("t3_rd_en_c0", 64'(bus.sb_rd_en), 64'd1);
    tick();
    for (int i = 1; i <= 3; i++) begin
      #1;
      check($sformatf("t3_cmd_c%0d", i), 64'(bus.proc2mem_command), 64'(BUS_NONE));
      check($sformatf("t3_retry_c%0d", i), 64'(dut.r_retry_cnt), 64'd0);
      tick();
    end
    bus.load_req = 1'b0;
    #1;
    check("t3_cmd_c4", 64'(bus.proc2mem_command), 64'(BUS_STORE));
    tick();
    #1;
    check("t3_commit", 64'(commit_count), 64'd6);

    // Fifteen rejections then acceptance
    bus.mem2proc_response = 4'h0;
    push_store(32'h0000_3000, 32'hCAFE_F00D, 1'b1);
    #1;
    check("t4_rd_en_c0", 64'(bus.sb_rd_en), 64'd1);
    tick();
    for (int i = 1; i <= 15; i++) begin
      #1;
      check($sformatf("t4_cmd_c%0d", i), 64'(bus.proc2mem_command), 64'(BUS_STORE));
      if (i == 15) check("t4_stall_before", 64'(stall_err), 64'd0);
      tick();
    end
    bus.mem2proc_response = 4'h2;
    #1;
    check("t4_stall_after", 64'(stall_err), 64'd1);
    check("t4_cmd_c16", 64'(bus.proc2mem_command), 64'(BUS_STORE));
    tick();
    #1;
    check("t4_commit", 64'(commit_count), 64'd7);
    check("t4_stall_sticky", 64'(stall_err), 64'd1);
    check("t4_retry_clr", 64'(dut.r_retry_cnt), 64'd0);

    // Drain overrides load priority
    bus.mem2proc_response = 4'h1;
    bus.load_req = 1'b1;
    drain_req = 1'b1;
    push_store(32'h0000_6000, 32'hA5A5_0001, 1'b1);
    push_store(32'h0000_6004, 32'hA5A5_0002, 1'b1);
    tick();
    #1;
    check("t5_cmd_c1", 64'(bus.proc2mem_command), 64'(BUS_STORE));
    tick();
    #1;
    check("t5_cmd_c2", 64'(bus.proc2mem_command), 64'(BUS_STORE));
    check("t5_not_drained", 64'(drained), 64'd0);
    tick();
    #1;
    check("t5_drained", 64'(drained), 64'd1);
    check("t5_commit", 64'(commit_count), 64'd9);
    drain_req = 1'b0;
    bus.load_req = 1'b0;

    // Reset while a store is being rejected
    bus.mem2proc_response = 4'h0;
    push_store(32'h0000_4000, 32'h7777_7777, 1'b0);
    tick();
    #1;
    check("t6_cmd_c1", 64'(bus.proc2mem_command), 64'(BUS_STORE));
    tick();
    rst = 1'b1;
    #1;
    check("t6_cmd_in_rst", 64'(bus.proc2mem_command), 64'(BUS_NONE));
    tick();
    rst = 1'b0;
    #1;
    check("t6_cmd_after", 64'(bus.proc2mem_command), 64'(BUS_NONE));
    check("t6_commit", 64'(commit_count), 64'd0);
    check("t6_stall", 64'(stall_err), 64'd0);
    check("t6_hold_vld", 64'(dut.r_state), 64'd0);
    check("t6_drained", 64'(drained), 64'd1);
    tick();
    tick();
    #1;
    check("sb_leftover", 64'(expq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
